// File: rtl/edge_detect_multi.sv
// N-channel edge detector: per-channel synchroniser, glitch filter, mode-gated edge pulse,
// sticky flag, saturating event counter and an aggregated interrupt.
module edge_detect_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       signal,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       edge_pulse,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CNT_W*CHANNELS-1:0] evt_cnt,
  output logic                      irq
);

  localparam int                FCNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCNT_W-1:0]      fcnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   sticky_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;
    logic                   accept;
    logic                   hit;
    mode_e                  ch_mode;

    assign s       = sync_q[SYNC_STAGES-1];
    assign ch_mode = mode_e'(mode[2*i +: 2]);
    // A transition is accepted once the new level has been seen FILTER_CYCLES times in a row.
    assign accept  = (s != level_q) && (fcnt_q == FCNT_LAST);

    always_comb begin
      hit = 1'b0;
      if (accept) begin
        unique case (ch_mode)
          MODE_OFF:  hit = 1'b0;
          MODE_RISE: hit = s;
          MODE_FALL: hit = ~s;
          MODE_BOTH: hit = 1'b1;
        endcase
      end
    end

    // NOTE: every flop here is reset, including the synchroniser, so a mid-operation
    // reset leaves no partial filter or sync history behind.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        // NOTE: non-blocking so every stage shifts from the pre-edge value of its neighbour.
        sync_q <= {sync_q[SYNC_STAGES-2:0], signal[i]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q <= 1'b0;
        fcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= hit;
        if (s == level_q) begin
          fcnt_q <= '0;
        end else if (accept) begin
          level_q <= s;
          fcnt_q  <= '0;
        end else begin
          fcnt_q <= fcnt_q + FCNT_W'(1);
        end
      end
    end

    // Set and count win over a same-cycle clear so no event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (pulse_q) begin
          sticky_q <= 1'b1;
        end else if (clr[i]) begin
          sticky_q <= 1'b0;
        end

        if (clr[i]) begin
          cnt_q <= pulse_q ? CNT_W'(1) : '0;
        end else if (pulse_q && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign level[i]                   = level_q;
    assign edge_pulse[i]              = pulse_q;
    assign sticky[i]                  = sticky_q;
    assign evt_cnt[CNT_W*i +: CNT_W]  = cnt_q;
  end

  assign irq = |sticky;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: default instance (a) plus a filtered,
// narrow-counter instance (b); pulses are checked against a cycle-stamped scoreboard.
module tb_edge_detect_multi;

  localparam int SYNC  = 2;
  localparam int FC_A  = 1;
  localparam int FC_B  = 3;
  localparam int LAT_A = 1 + SYNC + FC_A - 1;
  localparam int LAT_B = 1 + SYNC + FC_B - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sig_a = '0, clr_a = '0, sig_b = '0, clr_b = '0;
  logic [7:0]  mode_a = '0, mode_b = '0;
  logic [3:0]  level_a, pulse_a, sticky_a, level_b, pulse_b, sticky_b;
  logic [31:0] cnt_a;
  logic [11:0] cnt_b;
  logic        irq_a, irq_b;

  edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC_A), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .signal(sig_a), .mode(mode_a), .clr(clr_a),
    .level(level_a), .edge_pulse(pulse_a), .sticky(sticky_a), .evt_cnt(cnt_a), .irq(irq_a)
  );

  edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC_B), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .signal(sig_b), .mode(mode_b), .clr(clr_b),
    .level(level_b), .edge_pulse(pulse_b), .sticky(sticky_b), .evt_cnt(cnt_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] ma;
    logic [3:0] mb;
  } exp_t;
  exp_t sb[$];

  function automatic void push_exp(int at, int inst, logic [3:0] mask);
    exp_t e;
    int   pos;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == at) begin
        if (inst == 0) sb[i].ma = sb[i].ma | mask;
        else           sb[i].mb = sb[i].mb | mask;
        return;
      end
    end
    e.cyc = at;
    e.ma  = (inst == 0) ? mask : 4'b0;
    e.mb  = (inst == 0) ? 4'b0 : mask;
    pos   = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > at) pos = i;
    sb.insert(pos, e);
  endfunction

  function automatic logic wants(logic [1:0] m, logic rise);
    return (m == 2'b11) || (rise && m == 2'b01) || (!rise && m == 2'b10);
  endfunction

  // Scoreboard consumer: every cycle out of reset, pulses must match the due entry or be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pulse_missed cyc=%0d expected a=%b b=%b", sb[0].cyc, sb[0].ma, sb[0].mb);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        checks++;
        if ({pulse_b, pulse_a} !== {sb[0].mb, sb[0].ma}) begin
          errors++;
          $display("FAIL pulse cyc=%0d got a=%b b=%b expected a=%b b=%b",
                   cyc, pulse_a, pulse_b, sb[0].ma, sb[0].mb);
        end
        void'(sb.pop_front());
      end else if ((pulse_a | pulse_b) !== 4'b0) begin
        checks++; errors++;
        $display("FAIL pulse_unexpected cyc=%0d got a=%b b=%b", cyc, pulse_a, pulse_b);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_a(int ch, logic v, int hold);
    if (v != sig_a[ch] && wants(mode_a[2*ch +: 2], v)) push_exp(cyc + LAT_A, 0, 4'(1 << ch));
    sig_a[ch] = v;
    tick(hold);
  endtask

  task automatic drive_b(int ch, logic v, int hold);
    if (v != sig_b[ch] && wants(mode_b[2*ch +: 2], v)) push_exp(cyc + LAT_B, 1, 4'(1 << ch));
    sig_b[ch] = v;
    tick(hold);
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({level_a, pulse_a, sticky_a, irq_a} !== 13'b0) begin
      errors++; $display("FAIL reset_a_flags got %b expected 0", {level_a, pulse_a, sticky_a, irq_a});
    end
    checks++;
    if (cnt_a !== 32'h0) begin errors++; $display("FAIL reset_a_cnt got %h expected 0", cnt_a); end
    checks++;
    if ({level_b, pulse_b, sticky_b, irq_b} !== 13'b0) begin
      errors++; $display("FAIL reset_b_flags got %b expected 0", {level_b, pulse_b, sticky_b, irq_b});
    end
    checks++;
    if (cnt_b !== 12'h0) begin errors++; $display("FAIL reset_b_cnt got %h expected 0", cnt_b); end
    #2 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic;
    mode_a = 8'hFF;
    drive_a(0, 1'b1, 4);
    checks++;
    if (level_a !== 4'b0001) begin errors++; $display("FAIL basic_level got %b expected 0001", level_a); end
    checks++;
    if (sticky_a !== 4'b0001) begin errors++; $display("FAIL basic_sticky got %b expected 0001", sticky_a); end
    checks++;
    if (cnt_a !== 32'h0000_0001) begin errors++; $display("FAIL basic_cnt got %h expected 00000001", cnt_a); end
    checks++;
    if (irq_a !== 1'b1) begin errors++; $display("FAIL basic_irq got %b expected 1", irq_a); end
    checks++;
    if ({level_b, sticky_b, irq_b} !== 9'b0) begin
      errors++; $display("FAIL basic_b_idle got %b expected 0", {level_b, sticky_b, irq_b});
    end
  endtask

  task automatic test_glitch;
    int c;
    mode_b = 8'b00_00_10_00;
    drive_b(1, 1'b1, 10);
    checks++;
    if (level_b[1] !== 1'b1) begin errors++; $display("FAIL glitch_rise_level got %b expected 1", level_b[1]); end
    sig_b[1] = 1'b0;
    tick(2);
    sig_b[1] = 1'b1;
    tick(8);
    checks++;
    if ({level_b[1], sticky_b[1], cnt_b[5:3]} !== 5'b1_0_000) begin
      errors++; $display("FAIL glitch_reject got %b expected 10000", {level_b[1], sticky_b[1], cnt_b[5:3]});
    end
    c = cyc;
    sig_b[1] = 1'b0;
    push_exp(c + LAT_B, 1, 4'b0010);
    tick(4);
    sig_b[1] = 1'b1;
    tick(2);
    checks++;
    if (level_b[1] !== 1'b0) begin errors++; $display("FAIL glitch_fall_level got %b expected 0", level_b[1]); end
    checks++;
    if (cnt_b[5:3] !== 3'd1) begin errors++; $display("FAIL glitch_cnt got %0d expected 1", cnt_b[5:3]); end
    tick(6);
    checks++;
    if (level_b[1] !== 1'b1) begin errors++; $display("FAIL glitch_relevel got %b expected 1", level_b[1]); end
  endtask

  task automatic test_mode;
    mode_a[5:4] = 2'b01;
    drive_a(2, 1'b1, 10);
    drive_a(2, 1'b0, 10);
    drive_a(2, 1'b1, 10);
    checks++;
    if (cnt_a[23:16] !== 8'd2) begin errors++; $display("FAIL mode_rise_cnt got %0d expected 2", cnt_a[23:16]); end
    mode_a[5:4] = 2'b00;
    drive_a(2, 1'b0, 10);
    checks++;
    if (level_a[2] !== 1'b0) begin errors++; $display("FAIL mode_off_level0 got %b expected 0", level_a[2]); end
    drive_a(2, 1'b1, 10);
    checks++;
    if (level_a[2] !== 1'b1) begin errors++; $display("FAIL mode_off_level1 got %b expected 1", level_a[2]); end
    checks++;
    if (cnt_a[23:16] !== 8'd2) begin errors++; $display("FAIL mode_off_cnt got %0d expected 2", cnt_a[23:16]); end
  endtask

  task automatic test_saturate;
    int c;
    mode_b[7:6] = 2'b01;
    for (int n = 0; n < 9; n++) begin
      drive_b(3, 1'b1, 8);
      drive_b(3, 1'b0, 8);
    end
    checks++;
    if (cnt_b[11:9] !== 3'd7) begin errors++; $display("FAIL sat_cnt got %0d expected 7", cnt_b[11:9]); end
    c = cyc;
    sig_b[3] = 1'b1;
    push_exp(c + LAT_B, 1, 4'b1000);
    tick(LAT_B);
    clr_b[3] = 1'b1;
    tick(1);
    clr_b[3] = 1'b0;
    checks++;
    if (cnt_b[11:9] !== 3'd1) begin errors++; $display("FAIL clr_pulse_cnt got %0d expected 1", cnt_b[11:9]); end
    checks++;
    if (sticky_b[3] !== 1'b1) begin errors++; $display("FAIL clr_pulse_sticky got %b expected 1", sticky_b[3]); end
    clr_b[3] = 1'b1;
    tick(1);
    clr_b[3] = 1'b0;
    checks++;
    if ({sticky_b[3], cnt_b[11:9]} !== 4'b0) begin
      errors++; $display("FAIL clr_only got %b expected 0000", {sticky_b[3], cnt_b[11:9]});
    end
  endtask

  task automatic test_clear;
    mode_a = 8'hFF;
    push_exp(cyc + LAT_A, 0, 4'hF);
    sig_a = ~sig_a;
    tick(LAT_A + 1);
    checks++;
    if ({sticky_a, irq_a} !== 5'b1111_1) begin
      errors++; $display("FAIL all_sticky got %b expected 11111", {sticky_a, irq_a});
    end
    clr_a = 4'hF;
    tick(1);
    clr_a = 4'h0;
    checks++;
    if (sticky_a !== 4'h0) begin errors++; $display("FAIL clear_sticky got %b expected 0000", sticky_a); end
    checks++;
    if (cnt_a !== 32'h0) begin errors++; $display("FAIL clear_cnt got %h expected 0", cnt_a); end
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL clear_irq got %b expected 0", irq_a); end
  endtask

  task automatic test_back_to_back;
    drive_a(1, ~sig_a[1], 1);
    drive_a(1, ~sig_a[1], LAT_A + 2);
    checks++;
    if (cnt_a[15:8] !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d expected 2", cnt_a[15:8]); end
    checks++;
    if (level_a[1] !== 1'b1) begin errors++; $display("FAIL b2b_level got %b expected 1", level_a[1]); end
  endtask

  task automatic test_mid_reset;
    logic [3:0] mask_a;
    logic [3:0] mask_b;
    mode_b[1:0] = 2'b01;
    sig_b[0] = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({level_a, pulse_a, sticky_a, irq_a, cnt_a} !== 45'b0) begin
      errors++; $display("FAIL midrst_a got %h expected 0", {level_a, pulse_a, sticky_a, irq_a, cnt_a});
    end
    checks++;
    if ({level_b, pulse_b, sticky_b, irq_b, cnt_b} !== 25'b0) begin
      errors++; $display("FAIL midrst_b got %h expected 0", {level_b, pulse_b, sticky_b, irq_b, cnt_b});
    end
    sb.delete();
    tick(1);
    mask_a = '0;
    mask_b = '0;
    for (int ch = 0; ch < 4; ch++) begin
      if (sig_a[ch] && wants(mode_a[2*ch +: 2], 1'b1)) mask_a[ch] = 1'b1;
      if (sig_b[ch] && wants(mode_b[2*ch +: 2], 1'b1)) mask_b[ch] = 1'b1;
    end
    push_exp(cyc + LAT_A, 0, mask_a);
    push_exp(cyc + LAT_B, 1, mask_b);
    #2 rst_n = 1'b1;
    tick(LAT_B + 2);
    checks++;
    if (level_a !== sig_a) begin errors++; $display("FAIL midrst_level_a got %b expected %b", level_a, sig_a); end
    checks++;
    if (level_b !== sig_b) begin errors++; $display("FAIL midrst_level_b got %b expected %b", level_b, sig_b); end
    checks++;
    if (sticky_b !== mask_b) begin errors++; $display("FAIL midrst_sticky_b got %b expected %b", sticky_b, mask_b); end
    checks++;
    if (cnt_b[2:0] !== 3'd1) begin errors++; $display("FAIL midrst_cnt_b0 got %0d expected 1", cnt_b[2:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_mode();
    test_saturate();
    test_clear();
    test_back_to_back();
    test_mid_reset();
    tick(4);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
